// File: rtl/chimera_mem_to_reg.sv
// chimera_mem_to_reg: bridges a grant/rvalid memory-style slave port onto a
// single-outstanding valid/ready register-bus master. One transaction is in
// flight at a time; an optional watchdog aborts a stalled register access
// and answers the memory side with an error response.
module chimera_mem_to_reg #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // memory-side slave
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic                   mem_we_i,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_be_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_rerror_o,
    // register-bus master request
    output logic                   reg_valid_o,
    output logic                   reg_write_o,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    // register-bus response
    input  logic                   reg_ready_i,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i,
    // status
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;

    // latched request, held for the whole BUSY phase
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   be_q;

    // registered memory-side response
    logic                   rvalid_q, rvalid_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   rerror_q, rerror_d;

    logic                   grant;
    logic                   timeout_fire;
    logic                   busy;

    assign busy  = (state_q == BUSY);
    // Gating with rst_ni keeps the grant low during reset cycles.
    assign grant = (state_q == IDLE) && mem_req_i && rst_ni;

    generate
        if (TimeoutCycles > 0) begin : g_timeout
            localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
            localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);

            logic [CntWidth-1:0] cnt_q, cnt_d;

            // Stall counter: cleared when a request is granted, counts BUSY
            // cycles without ready and saturates at the limit.
            always_comb begin
                cnt_d = cnt_q;
                if (grant) begin
                    cnt_d = '0;
                end else if (busy && !reg_ready_i && (cnt_q != CntMax)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Stall counter register.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Fires in the BUSY cycle whose stall would bring the count to
            // the limit; a ready in that same cycle wins.
            assign timeout_fire = busy && !reg_ready_i && rst_ni &&
                                  (cnt_q == CntMax - 1'b1);
        end else begin : g_no_timeout
            assign timeout_fire = 1'b0;
        end
    endgenerate

    // Next-state and response computation.
    always_comb begin
        state_d  = state_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        rerror_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (reg_ready_i) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rerror_d = reg_error_i;
                    rdata_d  = we_q ? '0 : reg_rdata_i;
                end else if (timeout_fire) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rerror_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset abandons any transaction silently.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerror_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerror_q <= rerror_d;
        end
    end

    // Capture the memory-side request on grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant) begin
            we_q    <= mem_we_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            be_q    <= mem_be_i;
        end
    end

    assign mem_gnt_o    = grant;
    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_rerror_o = rerror_q;

    // Request fields are quiet outside BUSY; write payload is zero on reads.
    assign reg_valid_o  = busy;
    assign reg_write_o  = busy && we_q;
    assign reg_addr_o   = busy ? addr_q : '0;
    assign reg_wdata_o  = (busy && we_q) ? wdata_q : '0;
    assign reg_wstrb_o  = (busy && we_q) ? be_q : '0;

    assign busy_o       = busy;
    assign timeout_o    = timeout_fire;

endmodule

// File: tb/tb_chimera_mem_to_reg.sv
// Directed bench for chimera_mem_to_reg with a 4-cycle watchdog.
module tb_chimera_mem_to_reg;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_i;
    logic        mem_gnt_o;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_be_i;
    logic        mem_rvalid_o;
    logic [31:0] mem_rdata_o;
    logic        mem_rerror_o;
    logic        reg_valid_o;
    logic        reg_write_o;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_ready_i;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;
    logic        busy_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    chimera_mem_to_reg #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mem_req_i   (mem_req_i),
        .mem_gnt_o   (mem_gnt_o),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_be_i    (mem_be_i),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o (mem_rdata_o),
        .mem_rerror_o(mem_rerror_o),
        .reg_valid_o (reg_valid_o),
        .reg_write_o (reg_write_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to just past the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_quiet(input string tag);
        chk({tag, "_busy"},   32'(busy_o),       32'h0);
        chk({tag, "_rvalid"}, 32'(reg_valid_o),  32'h0);
        chk({tag, "_raddr"},  reg_addr_o,        32'h0);
        chk({tag, "_mvalid"}, 32'(mem_rvalid_o), 32'h0);
        chk({tag, "_mrdata"}, mem_rdata_o,       32'h0);
        chk({tag, "_mrerr"},  32'(mem_rerror_o), 32'h0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        mem_req_i   = 1'b1;   // request during reset must not be granted
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        mem_be_i    = 4'h0;
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'h0;
        reg_error_i = 1'b0;

        // ---- reset ----
        step();
        step();
        chk("rst_gnt",   32'(mem_gnt_o),   32'h0);
        chk("rst_write", 32'(reg_write_o), 32'h0);
        chk("rst_wstrb", 32'(reg_wstrb_o), 32'h0);
        chk("rst_wdata", reg_wdata_o,      32'h0);
        chk("rst_tmo",   32'(timeout_o),   32'h0);
        idle_quiet("rst");
        mem_req_i = 1'b0;
        rst_ni    = 1'b1;
        step();

        // ---- read, ready one cycle after grant ----
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100;
        mem_wdata_i = 32'hDEADBEEF; mem_be_i = 4'hF;
        #1 chk("rd_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        mem_req_i = 1'b0; reg_ready_i = 1'b1; reg_rdata_i = 32'hCAFEF00D;
        #1;
        chk("rd_busy",  32'(busy_o),      32'h1);
        chk("rd_valid", 32'(reg_valid_o), 32'h1);
        chk("rd_write", 32'(reg_write_o), 32'h0);
        chk("rd_addr",  reg_addr_o,       32'h100);
        chk("rd_wstrb", 32'(reg_wstrb_o), 32'h0);
        chk("rd_wdata", reg_wdata_o,      32'h0);
        chk("rd_nognt", 32'(mem_gnt_o),   32'h0);
        chk("rd_early", 32'(mem_rvalid_o), 32'h0);
        step();
        reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
        #1;
        chk("rd_rvalid", 32'(mem_rvalid_o), 32'h1);
        chk("rd_rdata",  mem_rdata_o,       32'hCAFEF00D);
        chk("rd_rerr",   32'(mem_rerror_o), 32'h0);
        chk("rd_vdrop",  32'(reg_valid_o),  32'h0);
        step();
        idle_quiet("rd_after");

        // ---- write with 3 stalls, error response ----
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h104;
        mem_wdata_i = 32'h12345678; mem_be_i = 4'h3;
        #1 chk("wr_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        mem_req_i = 1'b0; mem_be_i = 4'hF; mem_wdata_i = 32'h0; mem_addr_i = 32'h0;
        reg_error_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wr_st_valid", 32'(reg_valid_o), 32'h1);
            chk("wr_st_write", 32'(reg_write_o), 32'h1);
            chk("wr_st_addr",  reg_addr_o,       32'h104);
            chk("wr_st_wdata", reg_wdata_o,      32'h12345678);
            chk("wr_st_wstrb", 32'(reg_wstrb_o), 32'h3);
            chk("wr_st_tmo",   32'(timeout_o),   32'h0);
            step();
        end
        // ready lands on the cycle the watchdog would fire: ready wins
        reg_ready_i = 1'b1; reg_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("wr_rdy_valid", 32'(reg_valid_o), 32'h1);
        chk("wr_rdy_tmo",   32'(timeout_o),   32'h0);
        step();
        reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = 32'h0;
        #1;
        chk("wr_rvalid", 32'(mem_rvalid_o), 32'h1);
        chk("wr_rdata",  mem_rdata_o,       32'h0);
        chk("wr_rerr",   32'(mem_rerror_o), 32'h1);
        chk("wr_tmo",    32'(timeout_o),    32'h0);
        step();
        idle_quiet("wr_after");

        // ---- back-to-back reads, req held, ready tied high ----
        mem_req_i = 1'b1; mem_we_i = 1'b0; reg_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_addr_i = 32'h200 + 32'(4 * k);
            #1;
            chk("b2b_gnt",  32'(mem_gnt_o), 32'h1);
            chk("b2b_idle", 32'(busy_o),    32'h0);
            if (k > 0) begin
                chk("b2b_rvalid", 32'(mem_rvalid_o), 32'h1);
                chk("b2b_rdata",  mem_rdata_o,       32'hA0000000 + 32'(k - 1));
            end
            step();
            reg_rdata_i = 32'hA0000000 + 32'(k);
            #1;
            chk("b2b_nognt", 32'(mem_gnt_o),    32'h0);
            chk("b2b_busy",  32'(busy_o),       32'h1);
            chk("b2b_addr",  reg_addr_o,        32'h200 + 32'(4 * k));
            chk("b2b_norv",  32'(mem_rvalid_o), 32'h0);
            step();
        end
        mem_req_i = 1'b0; reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
        #1;
        chk("b2b_last_rv", 32'(mem_rvalid_o), 32'h1);
        chk("b2b_last_rd", mem_rdata_o,       32'hA0000003);
        step();
        idle_quiet("b2b_after");

        // ---- timeout: ready never arrives ----
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300;
        #1 chk("to_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        mem_req_i = 1'b0; reg_rdata_i = 32'h55AA55AA;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_valid", 32'(reg_valid_o),  32'h1);
            chk("to_pulse", 32'(timeout_o),    (i == 3) ? 32'h1 : 32'h0);
            chk("to_norv",  32'(mem_rvalid_o), 32'h0);
            step();
        end
        #1;
        chk("to_vdrop",  32'(reg_valid_o),  32'h0);
        chk("to_busy",   32'(busy_o),       32'h0);
        chk("to_tmo_lo", 32'(timeout_o),    32'h0);
        chk("to_rvalid", 32'(mem_rvalid_o), 32'h1);
        chk("to_rerr",   32'(mem_rerror_o), 32'h1);
        chk("to_rdata",  mem_rdata_o,       32'h0);
        step();
        reg_rdata_i = 32'h0;
        idle_quiet("to_after");

        // ---- zero-strobe write still forwarded ----
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h500;
        mem_wdata_i = 32'h0BADF00D; mem_be_i = 4'h0;
        #1 chk("zb_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        mem_req_i = 1'b0; reg_ready_i = 1'b1;
        #1;
        chk("zb_write", 32'(reg_write_o), 32'h1);
        chk("zb_wstrb", 32'(reg_wstrb_o), 32'h0);
        chk("zb_wdata", reg_wdata_o,      32'h0BADF00D);
        step();
        reg_ready_i = 1'b0;
        #1 chk("zb_rvalid", 32'(mem_rvalid_o), 32'h1);
        step();

        // ---- reset in the middle of BUSY ----
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400;
        #1 chk("rb_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        rst_ni = 1'b0; reg_ready_i = 1'b1; reg_rdata_i = 32'h77777777;
        #1 chk("rb_rst_gnt", 32'(mem_gnt_o), 32'h0);
        step();
        rst_ni = 1'b1; mem_req_i = 1'b0; reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
        #1;
        idle_quiet("rb_post");
        chk("rb_tmo", 32'(timeout_o), 32'h0);
        step();
        chk("rb_norv", 32'(mem_rvalid_o), 32'h0);
        mem_req_i = 1'b1; mem_addr_i = 32'h408;
        #1 chk("rb2_gnt", 32'(mem_gnt_o), 32'h1);
        step();
        mem_req_i = 1'b0; reg_ready_i = 1'b1; reg_rdata_i = 32'h13572468;
        #1 chk("rb2_addr", reg_addr_o, 32'h408);
        step();
        reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
        #1;
        chk("rb2_rvalid", 32'(mem_rvalid_o), 32'h1);
        chk("rb2_rdata",  mem_rdata_o,       32'h13572468);
        chk("rb2_rerr",   32'(mem_rerror_o), 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chimera_mem_to_reg.md
CHIMERA_MEM_TO_REG -- requirements
Module: chimera_mem_to_reg

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, address width of both sides.
REQ-002 SHALL have parameter DataWidth, default 32, data width of both sides; a multiple of 8.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, number of BUSY cycles before abort; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  single clock for all state.
REQ-005 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_req_i  in  1  memory-side request.
REQ-007 SHALL have port mem_gnt_o  out  1  request accepted this cycle.
REQ-008 SHALL have port mem_we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port mem_addr_i  in  AddrWidth  byte address.
REQ-010 SHALL have port mem_wdata_i  in  DataWidth  write data.
REQ-011 SHALL have port mem_be_i  in  DataWidth/8  byte enables.
REQ-012 SHALL have port mem_rvalid_o  out  1  response valid, one per grant, reads and writes.
REQ-013 SHALL have port mem_rdata_o  out  DataWidth  read data.
REQ-014 SHALL have port mem_rerror_o  out  1  response error.
REQ-015 SHALL have ports reg_valid_o  out  1, reg_write_o  out  1, reg_addr_o  out  AddrWidth, reg_wdata_o  out  DataWidth, reg_wstrb_o  out  DataWidth/8: register-bus master request.
REQ-016 SHALL have ports reg_ready_i  in  1, reg_rdata_i  in  DataWidth, reg_error_i  in  1: register-bus response.
REQ-017 SHALL have port busy_o  out  1  high while a transaction is outstanding (state BUSY).
REQ-018 SHALL have port timeout_o  out  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-019 SHALL implement FSM states IDLE and BUSY.
REQ-020 In IDLE: mem_gnt_o = mem_req_i; a granted request SHALL be latched (we, addr, wdata, be) and the state SHALL go to BUSY the next cycle.
REQ-021 In BUSY: mem_gnt_o SHALL be 0; reg_valid_o SHALL be 1; reg_* request fields SHALL be driven from the latched request and held stable until reg_ready_i.
REQ-022 reg_write_o = latched we; reg_wstrb_o = latched be on writes, all-zero on reads; reg_wdata_o = latched wdata on writes, zero on reads; reg_addr_o = latched addr, unmodified.
REQ-023 In BUSY with reg_ready_i=1, the FSM SHALL go to IDLE and SHALL assert mem_rvalid_o exactly one cycle later, with mem_rerror_o = reg_error_i and mem_rdata_o = reg_rdata_i for reads and zero for writes.
REQ-024 mem_rvalid_o SHALL be a registered one-cycle pulse; mem_rdata_o and mem_rerror_o SHALL be zero whenever mem_rvalid_o is 0.
REQ-025 A new request SHALL be grantable in the same cycle as mem_rvalid_o; minimum issue interval is 2 cycles (grant T, ready T+1, rvalid and next grant T+2).
REQ-026 A BUSY cycle counter SHALL clear on entering BUSY and increment each BUSY cycle without reg_ready_i.
REQ-027 With TimeoutCycles>0, when the counter reaches TimeoutCycles without reg_ready_i, the FSM SHALL drop reg_valid_o, return to IDLE, pulse timeout_o, and issue the response one cycle later with mem_rerror_o=1 and mem_rdata_o=0.
REQ-028 If reg_ready_i arrives in the same cycle the timeout would fire, ready SHALL take precedence; no timeout occurs.
REQ-029 Counter width SHALL be $clog2(TimeoutCycles+1) and SHALL saturate, never wrap; with TimeoutCycles=0 the counter logic SHALL be removed.
REQ-030 mem_req_i with mem_be_i all-zero on a write SHALL still be forwarded as a write with zero strobes.

Reset
REQ-031 While rst_ni=0 at a clock edge: state IDLE, counter 0, latched request cleared; mem_gnt_o=0, mem_rvalid_o=0, mem_rdata_o=0, mem_rerror_o=0, reg_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_wdata_o=0, reg_wstrb_o=0, busy_o=0, timeout_o=0.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no mem_rvalid_o pulse.
REQ-033 mem_gnt_o SHALL be 0 in any cycle where rst_ni=0.

Verification
REQ-034 Read: req addr 0x100, reg_ready_i one cycle after grant with rdata 0xCAFEF00D -> reg_valid_o 1 cycle, reg_wstrb_o 0, mem_rvalid_o at grant+2 with rdata 0xCAFEF00D, rerror 0.
REQ-035 Write: addr 0x104, wdata 0x12345678, be 0x3, ready after 3 stall cycles, reg_error_i=1 -> reg_wstrb_o 0x3 stable across stalls, mem_rvalid_o 1 cycle after ready, rdata 0, rerror 1.
REQ-036 Back-to-back: mem_req_i held high for 4 requests, reg_ready_i tied 1 -> grants every 2 cycles, 4 rvalid pulses in order, no grant while busy_o=1.
REQ-037 Timeout with TimeoutCycles=4: reg_ready_i tied 0 -> reg_valid_o high 4 cycles then low, timeout_o pulse, mem_rvalid_o next cycle with rerror 1, rdata 0; ready on the 4th cycle -> normal response, no timeout_o.
REQ-038 Reset mid-BUSY: rst_ni low for 1 cycle after grant -> all outputs 0 next cycle, no mem_rvalid_o, next request handled normally.
